// File: rtl/ex_pkg.sv
// Shared types and constants for the ex_cal operand scheduler.
package ex_pkg;

    // Operand is unsigned Q4.11, result is unsigned Q15.11.
    localparam int X_W    = 15;
    localparam int R_W    = 26;
    localparam int FRAC_W = 11;

    // Largest operand ex_cal accepts: just below 10.0 in Q4.11 (20479).
    localparam logic [X_W-1:0] X_MAX   = X_W'((10 << FRAC_W) - 1);
    // Result reported for an out-of-range operand: all ones.
    localparam logic [R_W-1:0] SAT_VAL = 26'h3FFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    // True when ex_cal cannot be trusted with this operand.
    function automatic logic x_out_of_range(input logic [X_W-1:0] x);
        return x > X_MAX;
    endfunction

endpackage

// File: rtl/ex_cal_sched_if.sv
// Operand stream, ex_cal request/answer pair and result stream of the scheduler.
interface ex_cal_sched_if;
    import ex_pkg::*;

    // Upstream operand stream
    logic           in_valid;
    logic           in_ready;
    logic [X_W-1:0] in_x;

    // Request/answer pair towards ex_cal
    logic [X_W-1:0] cal_x;
    logic           cal_valid;
    logic [R_W-1:0] cal_result;
    logic           cal_done;

    // Downstream result stream
    logic           out_valid;
    logic           out_ready;
    logic [R_W-1:0] out_result;
    logic [X_W-1:0] out_x;
    logic           out_sat;
    logic           out_timeout;

    logic           busy;

    // Scheduler side
    modport slave (
        input  in_valid, in_x, cal_result, cal_done, out_ready,
        output in_ready, cal_x, cal_valid, out_valid, out_result,
               out_x, out_sat, out_timeout, busy
    );

    // Environment side: operand source, ex_cal and result sink
    modport master (
        output in_valid, in_x, cal_result, cal_done, out_ready,
        input  in_ready, cal_x, cal_valid, out_valid, out_result,
               out_x, out_sat, out_timeout, busy
    );

endinterface

// File: rtl/ex_sfifo.sv
// Synchronous FIFO with wrapping pointers, full/empty flags and an occupancy count.
module ex_sfifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4      // power of two, at least 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses a push even when it pops in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: written on push only.
    // NOTE: the storage array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/ex_cal_sched.sv
// Operand scheduler and result buffer in front of the ex_cal exponential unit.
// Queues operands, issues one request at a time, and holds each answer
// (or a saturation / timeout marker) until downstream accepts it.
module ex_cal_sched
    import ex_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic          clk,
    input  logic          rst,
    ex_cal_sched_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [X_W-1:0]   w_head;
    logic             w_head_sat;

    logic             w_capture;
    logic             w_expire;
    logic             w_release;

    logic [X_W-1:0]   r_op;
    logic [X_W-1:0]   r_cal_x;
    logic [R_W-1:0]   r_result;
    logic             r_sat;
    logic             r_timeout;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_inc;

    assign w_push = bus.in_valid && !w_full;

    ex_sfifo #(
        .WIDTH (X_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.in_x),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_sat  = x_out_of_range(w_head);
    assign w_timer_inc = r_timer + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_expire  = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = w_head_sat ? HOLD : ISSUE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                // An answer wins over expiry in the same cycle. w_timer_inc counts
                // the current WAIT cycle, so expiry lands on the TIMEOUT-th one.
                if (bus.cal_done) begin
                    w_capture = 1'b1;
                    w_next    = HOLD;
                end else if (w_timer_inc == TMR_W'(TIMEOUT)) begin
                    w_expire = 1'b1;
                    w_next   = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand, request, timer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_cal_x   <= '0;
            r_result  <= '0;
            r_sat     <= 1'b0;
            r_timeout <= 1'b0;
            r_timer   <= '0;
        end else begin
            if (w_pop) begin
                r_op <= w_head;
                if (w_head_sat) begin
                    r_result <= SAT_VAL;
                    r_sat    <= 1'b1;
                end else begin
                    // cal_x only moves for operands actually sent to ex_cal.
                    r_cal_x <= w_head;
                end
            end

            if (r_state == ISSUE) begin
                r_timer <= '0;
            end else if (r_state == WAIT) begin
                r_timer <= w_timer_inc;
            end

            if (w_capture) begin
                r_result <= bus.cal_result;
            end

            if (w_expire) begin
                r_result  <= '0;
                r_timeout <= 1'b1;
            end

            if (w_release) begin
                r_sat     <= 1'b0;
                r_timeout <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.cal_x       = r_cal_x;
    assign bus.cal_valid   = (r_state == ISSUE);
    assign bus.out_valid   = (r_state == HOLD);
    assign bus.out_result  = r_result;
    assign bus.out_x       = r_op;
    assign bus.out_sat     = r_sat;
    assign bus.out_timeout = r_timeout;
    assign bus.busy        = (r_state != IDLE) || (w_count != '0);

endmodule
